// File: rtl/multi_tap_dispenser_if.sv
// Bundle of the per-tap request, interlock and valve/status signals of the
// multi-tap dispenser. The master side (button debouncers / supply monitor)
// drives requests; the slave side (dispenser core) drives valves and status.
interface multi_tap_dispenser_if #(
  parameter int N_TAPS  = 4,
  parameter int TIMER_W = 4
);
  localparam int CNT_W = $clog2(N_TAPS + 1);

  logic [N_TAPS-1:0]         start_dispense;
  logic [N_TAPS-1:0]         stop_dispense;
  logic [N_TAPS-1:0]         long_mode;
  logic                      tank_empty;

  logic [N_TAPS*TIMER_W-1:0] timer;
  logic [N_TAPS-1:0]         water_flow;
  logic                      dispense_active;
  logic [N_TAPS-1:0]         timeout_done;
  logic [N_TAPS-1:0]         start_reject;
  logic [CNT_W-1:0]          active_count;

  modport master (
    output start_dispense, stop_dispense, long_mode, tank_empty,
    input  timer, water_flow, dispense_active, timeout_done, start_reject, active_count
  );

  modport slave (
    input  start_dispense, stop_dispense, long_mode, tank_empty,
    output timer, water_flow, dispense_active, timeout_done, start_reject, active_count
  );
endinterface

// File: rtl/multi_tap_dispenser.sv
// N-tap water dispenser core. Each tap runs IDLE -> FLOW -> COOL -> IDLE with a
// limit chosen at grant time; a shared supply caps concurrent FLOW taps
// (lowest index wins) and a tank-empty interlock closes every valve.
module multi_tap_dispenser #(
  parameter int N_TAPS      = 4,
  parameter int TIMER_W     = 4,
  parameter int SHORT_LIMIT = 5,
  parameter int LONG_LIMIT  = 10,
  parameter int COOLDOWN    = 2,
  parameter int MAX_ACTIVE  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  multi_tap_dispenser_if.slave   bus
);
  localparam int CNT_W  = $clog2(N_TAPS + 1);
  localparam int COOL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  typedef enum logic [1:0] {IDLE, FLOW, COOL} tap_state_e;

  // Where a tap goes when it leaves FLOW: straight to IDLE if there is no cooldown.
  localparam tap_state_e EXIT_STATE = (COOLDOWN == 0) ? IDLE : COOL;

  tap_state_e          r_state [N_TAPS];
  logic [TIMER_W-1:0]  r_timer [N_TAPS];
  logic [TIMER_W-1:0]  r_limit [N_TAPS];
  logic [COOL_W-1:0]   r_cool  [N_TAPS];
  logic [N_TAPS-1:0]   r_water_flow;
  logic [N_TAPS-1:0]   r_timeout_done;
  logic [N_TAPS-1:0]   r_start_reject;
  logic [CNT_W-1:0]    r_active_count;
  logic                r_dispense_active;

  tap_state_e          w_state_nxt [N_TAPS];
  logic [TIMER_W-1:0]  w_timer_nxt [N_TAPS];
  logic [TIMER_W-1:0]  w_limit_nxt [N_TAPS];
  logic [COOL_W-1:0]   w_cool_nxt  [N_TAPS];
  logic [N_TAPS-1:0]   w_stay_flow;
  logic [N_TAPS-1:0]   w_timeout_nxt;
  logic [N_TAPS-1:0]   w_reject_nxt;
  logic [N_TAPS-1:0]   w_flow_nxt;
  logic [CNT_W-1:0]    w_busy;
  logic [CNT_W-1:0]    w_granted;
  logic [CNT_W-1:0]    w_count_nxt;

  // Next state of every tap: FLOW exits first, then grants in index order.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no path leaves it unassigned (no latch).
    w_busy        = '0;
    w_granted     = '0;
    w_count_nxt   = '0;
    w_stay_flow   = '0;
    w_timeout_nxt = '0;
    w_reject_nxt  = '0;
    w_flow_nxt    = '0;

    // Taps still flowing after this edge occupy supply slots; exiting taps free theirs.
    for (int i = 0; i < N_TAPS; i++) begin
      w_stay_flow[i] = (r_state[i] == FLOW) && !bus.tank_empty && !bus.stop_dispense[i] &&
                       (r_timer[i] != r_limit[i] - TIMER_W'(1));
      // NOTE: blocking '=' inside always_comb so the running count is visible to later iterations.
      if (w_stay_flow[i]) w_busy = w_busy + CNT_W'(1);
    end

    for (int i = 0; i < N_TAPS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_timer_nxt[i] = r_timer[i];
      w_limit_nxt[i] = r_limit[i];
      w_cool_nxt[i]  = r_cool[i];

      unique case (r_state[i])
        IDLE: begin
          if (bus.start_dispense[i]) begin
            if (!bus.tank_empty && ((w_busy + w_granted) < CNT_W'(MAX_ACTIVE))) begin
              w_state_nxt[i] = FLOW;
              w_timer_nxt[i] = '0;
              w_limit_nxt[i] = bus.long_mode[i] ? TIMER_W'(LONG_LIMIT) : TIMER_W'(SHORT_LIMIT);
              w_granted      = w_granted + CNT_W'(1);
            end else begin
              w_reject_nxt[i] = 1'b1;
            end
          end
        end
        FLOW: begin
          if (bus.tank_empty || bus.stop_dispense[i]) begin
            w_state_nxt[i] = EXIT_STATE;
            w_cool_nxt[i]  = '0;
          end else if (!w_stay_flow[i]) begin
            w_state_nxt[i]   = EXIT_STATE;
            w_cool_nxt[i]    = '0;
            w_timer_nxt[i]   = r_limit[i];
            w_timeout_nxt[i] = 1'b1;
          end else begin
            w_timer_nxt[i] = r_timer[i] + TIMER_W'(1);
          end
        end
        COOL: begin
          w_reject_nxt[i] = bus.start_dispense[i];
          if (r_cool[i] == COOL_W'(COOLDOWN - 1)) begin
            w_state_nxt[i] = IDLE;
          end else begin
            w_cool_nxt[i] = r_cool[i] + COOL_W'(1);
          end
        end
        default: w_state_nxt[i] = IDLE;
      endcase

      w_flow_nxt[i] = (w_state_nxt[i] == FLOW);
      if (w_flow_nxt[i]) w_count_nxt = w_count_nxt + CNT_W'(1);
    end
  end

  // State and registered outputs; reset wins over every other update.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the per-tap arrays are a handful of flops, not RAM, so they are all cleared on reset.
      for (int i = 0; i < N_TAPS; i++) begin
        r_state[i] <= IDLE;
        r_timer[i] <= '0;
        r_limit[i] <= '0;
        r_cool[i]  <= '0;
      end
      r_water_flow      <= '0;
      r_timeout_done    <= '0;
      r_start_reject    <= '0;
      r_active_count    <= '0;
      r_dispense_active <= 1'b0;
    end else begin
      for (int i = 0; i < N_TAPS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_timer[i] <= w_timer_nxt[i];
        r_limit[i] <= w_limit_nxt[i];
        r_cool[i]  <= w_cool_nxt[i];
      end
      r_water_flow      <= w_flow_nxt;
      r_timeout_done    <= w_timeout_nxt;
      r_start_reject    <= w_reject_nxt;
      r_active_count    <= w_count_nxt;
      r_dispense_active <= |w_flow_nxt;
    end
  end

  for (genvar g = 0; g < N_TAPS; g++) begin : g_timer_out
    assign bus.timer[g*TIMER_W +: TIMER_W] = r_timer[g];
  end

  assign bus.water_flow      = r_water_flow;
  assign bus.timeout_done    = r_timeout_done;
  assign bus.start_reject    = r_start_reject;
  assign bus.active_count    = r_active_count;
  assign bus.dispense_active = r_dispense_active;
endmodule

// File: tb/tb_multi_tap_dispenser.sv
// Bench for multi_tap_dispenser: a hand-written vector table, directed
// multi-cycle sequences, then random traffic against a behavioural model.
module tb_multi_tap_dispenser;
  localparam int N_TAPS      = 4;
  localparam int TIMER_W     = 4;
  localparam int SHORT_LIMIT = 5;
  localparam int LONG_LIMIT  = 10;
  localparam int COOLDOWN    = 2;
  localparam int MAX_ACTIVE  = 2;
  localparam int CNT_W       = $clog2(N_TAPS + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_tap_dispenser_if #(.N_TAPS(N_TAPS), .TIMER_W(TIMER_W)) bus ();

  multi_tap_dispenser #(
    .N_TAPS(N_TAPS), .TIMER_W(TIMER_W), .SHORT_LIMIT(SHORT_LIMIT),
    .LONG_LIMIT(LONG_LIMIT), .COOLDOWN(COOLDOWN), .MAX_ACTIVE(MAX_ACTIVE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a tap is flowing, cooling (cycles left) or idle.
  bit                m_flow [N_TAPS];
  int                m_timer[N_TAPS];
  int                m_limit[N_TAPS];
  int                m_cool [N_TAPS];
  logic [N_TAPS-1:0] e_tmo;
  logic [N_TAPS-1:0] e_rej;

  task automatic model_step(input logic [N_TAPS-1:0] st, sp, lm, input logic te, rs);
    int busy;
    int granted;
    e_tmo = '0;
    e_rej = '0;
    if (rs) begin
      for (int i = 0; i < N_TAPS; i++) begin
        m_flow[i] = 0; m_timer[i] = 0; m_limit[i] = 0; m_cool[i] = 0;
      end
      return;
    end
    busy = 0;
    for (int i = 0; i < N_TAPS; i++)
      if (m_flow[i] && !te && !sp[i] && (m_timer[i] + 1 != m_limit[i])) busy++;
    granted = 0;
    for (int i = 0; i < N_TAPS; i++) begin
      if (m_flow[i]) begin
        if (te || sp[i]) begin
          m_flow[i] = 0; m_cool[i] = COOLDOWN;
        end else if (m_timer[i] + 1 == m_limit[i]) begin
          m_flow[i] = 0; m_cool[i] = COOLDOWN; m_timer[i] = m_limit[i]; e_tmo[i] = 1'b1;
        end else begin
          m_timer[i]++;
        end
      end else if (m_cool[i] > 0) begin
        e_rej[i] = st[i];
        m_cool[i]--;
      end else if (st[i]) begin
        if (!te && (busy + granted < MAX_ACTIVE)) begin
          m_flow[i]  = 1;
          m_timer[i] = 0;
          m_limit[i] = lm[i] ? LONG_LIMIT : SHORT_LIMIT;
          granted++;
        end else begin
          e_rej[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [N_TAPS-1:0]         ef;
    logic [N_TAPS*TIMER_W-1:0] et;
    int                        cnt;
    cnt = 0;
    for (int i = 0; i < N_TAPS; i++) begin
      ef[i] = m_flow[i];
      et[i*TIMER_W +: TIMER_W] = TIMER_W'(m_timer[i]);
      if (m_flow[i]) cnt++;
    end
    check("model_water_flow", 64'(bus.water_flow), 64'(ef));
    check("model_timer", 64'(bus.timer), 64'(et));
    check("model_timeout_done", 64'(bus.timeout_done), 64'(e_tmo));
    check("model_start_reject", 64'(bus.start_reject), 64'(e_rej));
    check("model_active_count", 64'(bus.active_count), 64'(cnt));
    check("model_dispense_active", 64'(bus.dispense_active), 64'(cnt != 0));
  endtask

  // Apply one cycle of inputs, step the model on the edge, compare 1 ns later.
  task automatic cycle(input logic [N_TAPS-1:0] st, sp, lm, input logic te, rs);
    bus.start_dispense = st;
    bus.stop_dispense  = sp;
    bus.long_mode      = lm;
    bus.tank_empty     = te;
    reset              = rs;
    @(posedge clk);
    model_step(st, sp, lm, te, rs);
    #1;
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0, '0, '0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [N_TAPS-1:0]         st, sp, lm;
    logic                      te, rs;
    logic [N_TAPS-1:0]         flow, tmo, rej;
    logic [CNT_W-1:0]          cnt;
    logic [N_TAPS*TIMER_W-1:0] tmr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Reset with starts held, short timeout on tap 0, cooldown rejects, regrant, stop.
    tbl[0]  = '{4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 3'd0, 16'h0000};
    tbl[1]  = '{4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 3'd0, 16'h0000};
    tbl[2]  = '{4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 3'd1, 16'h0000};
    tbl[3]  = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 3'd1, 16'h0001};
    tbl[4]  = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 3'd1, 16'h0002};
    tbl[5]  = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 3'd1, 16'h0003};
    tbl[6]  = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 3'd1, 16'h0004};
    tbl[7]  = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h1, 4'h0, 3'd0, 16'h0005};
    tbl[8]  = '{4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 3'd0, 16'h0005};
    tbl[9]  = '{4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 3'd0, 16'h0005};
    tbl[10] = '{4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 3'd1, 16'h0000};
    tbl[11] = '{4'h0, 4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0, 16'h0000};

    bus.start_dispense = '0;
    bus.stop_dispense  = '0;
    bus.long_mode      = '0;
    bus.tank_empty     = 1'b0;
    reset              = 1'b1;
    #2;

    for (int v = 0; v < 12; v++) begin
      cycle(tbl[v].st, tbl[v].sp, tbl[v].lm, tbl[v].te, tbl[v].rs);
      check($sformatf("tbl%0d_flow", v), 64'(bus.water_flow), 64'(tbl[v].flow));
      check($sformatf("tbl%0d_timeout", v), 64'(bus.timeout_done), 64'(tbl[v].tmo));
      check($sformatf("tbl%0d_reject", v), 64'(bus.start_reject), 64'(tbl[v].rej));
      check($sformatf("tbl%0d_count", v), 64'(bus.active_count), 64'(tbl[v].cnt));
      check($sformatf("tbl%0d_active", v), 64'(bus.dispense_active), 64'(tbl[v].cnt != 0));
      check($sformatf("tbl%0d_timer", v), 64'(bus.timer), 64'(tbl[v].tmr));
    end
    idle(2);

    // Tap 1 long mode, stopped on its 4th flow cycle.
    cycle(4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0);
    check("b_grant_flow", 64'(bus.water_flow), 64'h2);
    idle(3);
    check("b_timer_before_stop", 64'(bus.timer[7:4]), 64'd3);
    cycle(4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0);
    check("b_stop_flow", 64'(bus.water_flow), 64'h0);
    check("b_stop_timer_hold", 64'(bus.timer[7:4]), 64'd3);
    check("b_stop_no_timeout", 64'(bus.timeout_done), 64'h0);
    cycle(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("b_cool_reject1", 64'(bus.start_reject), 64'h2);
    cycle(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("b_cool_reject2", 64'(bus.start_reject), 64'h2);
    idle(1);

    // Supply cap: three simultaneous starts, then a slot handed over on one edge.
    cycle(4'b0111, 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("c_flow", 64'(bus.water_flow), 64'h3);
    check("c_reject", 64'(bus.start_reject), 64'h4);
    check("c_count", 64'(bus.active_count), 64'd2);
    cycle(4'b0100, 4'b0001, 4'b0000, 1'b0, 1'b0);
    check("c_handover_flow", 64'(bus.water_flow), 64'h6);
    check("c_handover_count", 64'(bus.active_count), 64'd2);
    check("c_handover_reject", 64'(bus.start_reject), 64'h0);
    cycle(4'b0000, 4'b0110, 4'b0000, 1'b0, 1'b0);
    check("c_stop_all", 64'(bus.water_flow), 64'h0);
    idle(2);

    // Tank-empty interlock.
    cycle(4'b1001, 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("d_flow", 64'(bus.water_flow), 64'h9);
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    check("d_tank_flow", 64'(bus.water_flow), 64'h0);
    check("d_tank_timeout", 64'(bus.timeout_done), 64'h0);
    cycle(4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0);
    check("d_tank_reject", 64'(bus.start_reject), 64'h2);
    idle(2);

    // Start held continuously on tap 0: flow, timeout, two cooldown rejects, regrant.
    for (int k = 0; k < 9; k++) begin
      cycle(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
      if (k <= 4) check($sformatf("e_flow%0d", k), 64'(bus.timer[3:0]), 64'(k));
      if (k == 5) check("e_timeout", 64'(bus.timeout_done), 64'h1);
      if (k == 5) check("e_timer_limit", 64'(bus.timer[3:0]), 64'd5);
      if (k == 6 || k == 7) check($sformatf("e_reject%0d", k), 64'(bus.start_reject), 64'h1);
      if (k == 8) check("e_regrant", 64'(bus.water_flow), 64'h1);
      if (k == 8) check("e_regrant_timer", 64'(bus.timer[3:0]), 64'd0);
    end
    cycle(4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0);
    idle(2);

    // Reset mid-flow.
    cycle(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
    idle(3);
    check("f_timer_before_reset", 64'(bus.timer[3:0]), 64'd3);
    cycle(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1);
    check("f_reset_timer", 64'(bus.timer), 64'h0);
    check("f_reset_flow", 64'(bus.water_flow), 64'h0);
    check("f_reset_count", 64'(bus.active_count), 64'd0);
    check("f_reset_timeout", 64'(bus.timeout_done), 64'h0);
    check("f_reset_reject", 64'(bus.start_reject), 64'h0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      cycle(N_TAPS'($urandom & $urandom),
            N_TAPS'($urandom & $urandom & $urandom),
            N_TAPS'($urandom),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/multi_tap_dispenser.md
Name: multi_tap_dispenser

Overview:
- Parametrised N-tap successor to the single-tap smart water dispenser.
- Each tap runs its own dispense FSM with a per-request selectable time limit and a post-dispense cooldown.
- A shared supply limits how many taps may flow at once; a tank-empty interlock forces every tap off.
- Sits between the per-tap button debouncers and the valve drivers.

Parameters:
- N_TAPS, 4, number of independent taps.
- TIMER_W, 4, width of each per-tap timer.
- SHORT_LIMIT, 5, flow cycles when long_mode=0; 1 ≤ value ≤ 2^TIMER_W-1.
- LONG_LIMIT, 10, flow cycles when long_mode=1; SHORT_LIMIT ≤ value ≤ 2^TIMER_W-1.
- COOLDOWN, 2, cycles in COOL before a tap returns to IDLE; 0 allowed.
- MAX_ACTIVE, 2, maximum taps in FLOW simultaneously; 1 ≤ value ≤ N_TAPS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start_dispense  in  N_TAPS  per-tap start request, level-sampled.
- stop_dispense  in  N_TAPS  per-tap manual stop.
- long_mode  in  N_TAPS  per-tap limit select; latched at grant.
- tank_empty  in  1  supply interlock.
- timer  out  N_TAPS*TIMER_W  per-tap elapsed flow count; tap i occupies [i*TIMER_W +: TIMER_W].
- water_flow  out  N_TAPS  valve open, asserted when the tap is in FLOW.
- dispense_active  out  1  OR of water_flow.
- timeout_done  out  N_TAPS  one-cycle pulse when a tap hits its limit.
- start_reject  out  N_TAPS  one-cycle pulse when a start is refused.
- active_count  out  $clog2(N_TAPS+1)  number of taps in FLOW.

Behaviour:
- Reset (synchronous, evaluated before anything else):
  - All taps go to IDLE; timers, cooldown counters and latched limits are cleared to 0.
  - All outputs are 0 on the cycle after the reset edge.
  - A reset during FLOW or COOL aborts the operation with no timeout_done pulse.
- Per-tap FSM states: IDLE, FLOW, COOL. All outputs are registered.
- IDLE, with start_dispense[i]=1:
  - If tank_empty=1: start_reject[i] pulses; the tap stays IDLE.
  - Otherwise a grant is evaluated. Granted if (taps currently in FLOW, after this edge's exits) + (granted lower-index taps this cycle) < MAX_ACTIVE. Lower index wins.
  - Granted: next state FLOW, timer=0, limit latched from long_mode[i].
  - Not granted: start_reject[i] pulses; the tap stays IDLE.
- A start in FLOW is ignored. A start in COOL produces a start_reject pulse and no state change.
- FLOW, priority order per edge:
  1. tank_empty: go to COOL, timer holds, no pulse.
  2. stop_dispense[i]: go to COOL, timer holds, no pulse.
  3. timer == limit-1: go to COOL, timer = limit, timeout_done[i] = 1 for one cycle.
  4. Otherwise: timer += 1.
- Consequences of the FLOW rules:
  - water_flow is high for exactly `limit` cycles on a timeout.
  - A stop on the same edge as the limit suppresses timeout_done.
- COOL:
  - cool_cnt starts at 0 and increments each cycle; at cool_cnt == COOLDOWN-1 the tap returns to IDLE.
  - If COOLDOWN=0, FLOW exits directly to IDLE with the same timer and pulse rules.
  - The timer holds its final value through COOL and IDLE until the next grant clears it.
- A tap leaving FLOW on an edge frees its slot for grants on that same edge.
- active_count and dispense_active are registered and reflect the post-edge FLOW set.
- stop_dispense in IDLE or COOL has no effect.

Test Plan:
- Reset held 2 cycles with starts asserted → all outputs 0, no reject pulses. Release, then one-cycle start[0] with long_mode=0 → water_flow[0] high exactly 5 cycles, timer 0→4 then 5. timeout_done[0] pulses with COOL entry; tap 0 is IDLE 2 cycles later.
- Tap 1 with long_mode=1; stop_dispense[1] asserted on the 4th flow cycle → water_flow[1] drops next edge, timer[1] holds 3, no timeout_done, COOL for 2 cycles.
- Same-cycle starts on taps 0, 1, 2 with MAX_ACTIVE=2 → taps 0 and 1 flow, start_reject[2]=1 for one cycle, active_count=2. Tap 0 is stopped and tap 2 starts on that same edge → tap 2 granted, active_count stays 2.
- tank_empty asserted while taps 0 and 3 flow → both water_flow bits clear next edge, no timeout pulses. A start during tank_empty → reject pulse.
- start[0] held continuously → tap flows 5 cycles, cools 2 cycles (start_reject[0] pulses each COOL cycle), then re-grants with timer restarting at 0.
- Reset asserted mid-FLOW at timer=3 → next cycle timer=0, water_flow=0, active_count=0, no timeout_done.
